// File: rtl/mem_stage.sv
// Memory-access stage: turns LW/SW/LB/SB into a held request/ready cache transaction
// and registers read data plus write-back controls; other instructions pass through.
module mem_stage (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        is_LB_SB,
  input  logic        mem_to_reg,
  input  logic        reg_dst,
  input  logic [1:0]  jump,
  input  logic [31:0] pc,
  input  logic [31:0] alu_result,
  input  logic [31:0] inst,
  input  logic [31:0] store_data,
  output logic        cache_req,
  output logic        cache_we,
  output logic [31:0] cache_addr,
  output logic [7:0]  cache_data_in [4],
  output logic [3:0]  cache_byte_en,
  input  logic        cache_ready,
  input  logic [7:0]  cache_data_out [4],
  output logic        wb_valid,
  output logic [7:0]  wb_data [4],
  output logic [1:0]  wb_mem_block,
  output logic        wb_is_LB_SB,
  output logic        wb_mem_to_reg,
  output logic        wb_reg_dst,
  output logic [1:0]  wb_jump,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_alu_result,
  output logic [31:0] wb_inst,
  output logic        mem_fault
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]  state;

  logic        h_we;
  logic [31:0] h_addr;
  logic [7:0]  h_data [4];
  logic [3:0]  h_be;
  logic [31:0] h_pc;
  logic [31:0] h_inst;
  logic [1:0]  h_jump;
  logic        h_mem_to_reg;
  logic        h_reg_dst;
  logic        h_is_LB_SB;

  logic        mem_op;
  logic        misaligned;
  logic        store_en;
  logic [7:0]  st_lane [4];
  logic [3:0]  st_be;

  assign mem_op     = mem_read | mem_write;
  assign misaligned = mem_op & ~is_LB_SB & (alu_result[1:0] != 2'b00);
  // Read wins when both mem_read and mem_write are set.
  assign store_en   = mem_write & ~mem_read;

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) st_lane[i] = '0;
    st_be = '0;
    if (store_en) begin
      if (is_LB_SB) begin
        st_lane[alu_result[1:0]] = store_data[7:0];
        st_be[alu_result[1:0]]   = 1'b1;
      end else begin
        st_lane[0] = store_data[31:24];
        st_lane[1] = store_data[23:16];
        st_lane[2] = store_data[15:8];
        st_lane[3] = store_data[7:0];
        st_be      = '1;
      end
    end
  end

  assign in_ready      = (state == IDLE);
  assign cache_req     = (state == ACCESS);
  assign cache_we      = h_we;
  assign cache_addr    = {h_addr[31:2], 2'b00};
  assign cache_byte_en = h_be;
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) cache_data_in[i] = h_data[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state         <= IDLE;
      h_we          <= 1'b0;
      h_addr        <= '0;
      h_be          <= '0;
      h_pc          <= '0;
      h_inst        <= '0;
      h_jump        <= '0;
      h_mem_to_reg  <= 1'b0;
      h_reg_dst     <= 1'b0;
      h_is_LB_SB    <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
        h_data[i]  <= '0;
        wb_data[i] <= '0;
      end
      wb_valid      <= 1'b0;
      wb_mem_block  <= '0;
      wb_is_LB_SB   <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_reg_dst    <= 1'b0;
      wb_jump       <= '0;
      wb_pc         <= '0;
      wb_alu_result <= '0;
      wb_inst       <= '0;
      mem_fault     <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (mem_op && !misaligned) begin
              h_we         <= store_en;
              h_addr       <= alu_result;
              h_be         <= st_be;
              h_pc         <= pc;
              h_inst       <= inst;
              h_jump       <= jump;
              h_mem_to_reg <= mem_to_reg;
              h_reg_dst    <= reg_dst;
              h_is_LB_SB   <= is_LB_SB;
              for (int unsigned i = 0; i < 4; i++) h_data[i] <= st_lane[i];
              state        <= ACCESS;
            end else begin
              // Misaligned word accesses complete as non-memory ops with the fault flag.
              wb_valid      <= 1'b1;
              wb_mem_block  <= alu_result[1:0];
              wb_is_LB_SB   <= is_LB_SB;
              wb_mem_to_reg <= mem_to_reg & ~misaligned;
              wb_reg_dst    <= reg_dst;
              wb_jump       <= jump;
              wb_pc         <= pc;
              wb_alu_result <= alu_result;
              wb_inst       <= inst;
              mem_fault     <= misaligned;
              for (int unsigned i = 0; i < 4; i++) wb_data[i] <= '0;
            end
          end
        end
        ACCESS: begin
          if (cache_ready) begin
            wb_valid      <= 1'b1;
            wb_mem_block  <= h_addr[1:0];
            wb_is_LB_SB   <= h_is_LB_SB;
            wb_mem_to_reg <= h_mem_to_reg;
            wb_reg_dst    <= h_reg_dst;
            wb_jump       <= h_jump;
            wb_pc         <= h_pc;
            wb_alu_result <= h_addr;
            wb_inst       <= h_inst;
            mem_fault     <= 1'b0;
            for (int unsigned i = 0; i < 4; i++)
              wb_data[i] <= h_we ? 8'h00 : cache_data_out[i];
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: issue-time reference model, a latency-randomising
// cache responder, and a write-back monitor that pops expectations as results appear.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        in_valid;
  logic        in_ready;
  logic        mem_read, mem_write, is_LB_SB, mem_to_reg, reg_dst;
  logic [1:0]  jump;
  logic [31:0] pc, alu_result, inst, store_data;
  logic        cache_req, cache_we;
  logic [31:0] cache_addr;
  logic [7:0]  cache_data_in [4];
  logic [3:0]  cache_byte_en;
  logic        cache_ready;
  logic [7:0]  cache_data_out [4];
  logic        wb_valid;
  logic [7:0]  wb_data [4];
  logic [1:0]  wb_mem_block;
  logic        wb_is_LB_SB, wb_mem_to_reg, wb_reg_dst;
  logic [1:0]  wb_jump;
  logic [31:0] wb_pc, wb_alu_result, wb_inst;
  logic        mem_fault;

  mem_stage dut (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready),
    .mem_read(mem_read), .mem_write(mem_write), .is_LB_SB(is_LB_SB),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .jump(jump),
    .pc(pc), .alu_result(alu_result), .inst(inst), .store_data(store_data),
    .cache_req(cache_req), .cache_we(cache_we), .cache_addr(cache_addr),
    .cache_data_in(cache_data_in), .cache_byte_en(cache_byte_en),
    .cache_ready(cache_ready), .cache_data_out(cache_data_out),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_mem_block(wb_mem_block),
    .wb_is_LB_SB(wb_is_LB_SB), .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_dst(wb_reg_dst),
    .wb_jump(wb_jump), .wb_pc(wb_pc), .wb_alu_result(wb_alu_result), .wb_inst(wb_inst),
    .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, alu, inst, data;
    logic [1:0]  jump, blk;
    logic        m2r, rdst, lbsb, fault, is_mem;
    int          exp_cyc;
  } wb_t;

  typedef struct {
    logic        we;
    logic [31:0] addr, data, rdata;
    logic [3:0]  be;
    int          lat;
  } req_t;

  wb_t  wb_q[$];
  req_t req_q[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   auto_cache = 1'b1;
  logic done_prev = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    done_prev <= cache_req && cache_ready;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
  endtask

  // Reference model applied when an instruction is accepted.
  task automatic send(input logic rd, input logic wr, input logic lbsb, input logic m2r,
                      input logic rdst, input logic [1:0] jp, input logic [31:0] p,
                      input logic [31:0] a, input logic [31:0] ins, input logic [31:0] sd,
                      input int lat, input logic [31:0] rdata, input bit expect_it);
    wb_t  w;
    req_t r;
    bit   is_mem, fault, go_cache, we;
    int   guard;
    @(negedge clk);
    mem_read = rd; mem_write = wr; is_LB_SB = lbsb; mem_to_reg = m2r; reg_dst = rdst;
    jump = jp; pc = p; alu_result = a; inst = ins; store_data = sd; in_valid = 1'b1;
    guard = 0;
    while (in_ready !== 1'b1) begin
      @(negedge clk);
      guard++;
      if (guard > 100) begin
        n_fail++;
        $display("FAIL in_ready_timeout actual=0 expected=1 (cycle %0d)", cyc);
        summary();
        $fatal(1, "in_ready never returned");
      end
    end
    is_mem   = rd || wr;
    fault    = is_mem && !lbsb && (a % 4 != 0);
    go_cache = is_mem && !fault;
    we       = wr && !rd;
    w.pc = p; w.alu = a; w.inst = ins; w.jump = jp; w.blk = a[1:0];
    w.rdst = rdst; w.lbsb = lbsb; w.fault = fault; w.is_mem = go_cache;
    w.m2r = fault ? 1'b0 : m2r;
    w.data = (go_cache && !we) ? rdata : 32'h0;
    w.exp_cyc = cyc + 1;
    r.we = we; r.addr = a - (a % 4); r.rdata = rdata; r.lat = lat;
    if (!we) begin
      r.data = 32'h0; r.be = 4'h0;
    end else if (lbsb) begin
      r.data = {24'h0, sd[7:0]} << (8 * (3 - int'(a[1:0])));
      r.be   = 4'b0001 << a[1:0];
    end else begin
      r.data = sd; r.be = 4'hF;
    end
    if (expect_it) begin
      wb_q.push_back(w);
      if (go_cache) req_q.push_back(r);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Cache responder: checks request fields every cycle they are presented.
  initial begin
    req_t cur;
    bit   busy;
    int   cnt;
    busy = 1'b0; cnt = 0;
    cache_ready = 1'b0;
    for (int i = 0; i < 4; i++) cache_data_out[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (auto_cache) begin
        if (busy && cache_ready) begin
          cache_ready = 1'b0;
          busy = 1'b0;
        end else if (cache_req === 1'b1) begin
          if (!busy) begin
            if (req_q.size() == 0) begin
              chk("unexpected_cache_req", 32'(cache_req), 32'h0);
              continue;
            end
            cur  = req_q.pop_front();
            busy = 1'b1;
            cnt  = cur.lat;
          end
          chk("cache_we", 32'(cache_we), 32'(cur.we));
          chk("cache_addr", cache_addr, cur.addr);
          chk("cache_byte_en", 32'(cache_byte_en), 32'(cur.be));
          if (cur.we)
            chk("cache_data_in", {cache_data_in[0], cache_data_in[1], cache_data_in[2],
                                  cache_data_in[3]}, cur.data);
          if (cnt == 0) begin
            cache_ready = 1'b1;
            cache_data_out[0] = cur.rdata[31:24];
            cache_data_out[1] = cur.rdata[23:16];
            cache_data_out[2] = cur.rdata[15:8];
            cache_data_out[3] = cur.rdata[7:0];
          end else begin
            cnt--;
          end
        end else if (busy) begin
          chk("cache_req_dropped", 32'(cache_req), 32'h1);
          busy = 1'b0;
        end
      end
    end
  end

  // Write-back monitor.
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (wb_valid === 1'b1) begin
        if (wb_q.size() == 0) begin
          chk("wb_valid_spurious", 32'(wb_valid), 32'h0);
        end else begin
          e = wb_q.pop_front();
          if (e.is_mem) begin
            chk("wb_after_cache_ready", 32'(done_prev), 32'h1);
            chk("wb_mem_block", 32'(wb_mem_block), 32'(e.blk));
          end else begin
            chk("wb_latency", cyc, e.exp_cyc);
          end
          chk("wb_data", {wb_data[0], wb_data[1], wb_data[2], wb_data[3]}, e.data);
          chk("wb_pc", wb_pc, e.pc);
          chk("wb_alu_result", wb_alu_result, e.alu);
          chk("wb_inst", wb_inst, e.inst);
          chk("wb_jump", 32'(wb_jump), 32'(e.jump));
          chk("wb_ctrl", {29'h0, wb_is_LB_SB, wb_mem_to_reg, wb_reg_dst},
              {29'h0, e.lbsb, e.m2r, e.rdst});
          chk("mem_fault", 32'(mem_fault), 32'(e.fault));
        end
      end
    end
  end

  initial begin
    int k, guard;
    logic        rd, wr, lbsb;
    logic [31:0] a;
    rst_b = 1'b0;
    in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; is_LB_SB = 1'b0;
    mem_to_reg = 1'b1; reg_dst = 1'b1; jump = 2'b11;
    pc = 32'h40; alu_result = 32'h100; inst = 32'h8C000000; store_data = 32'h55;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_cache_req", 32'(cache_req), 32'h0);
    chk("rst_wb_valid", 32'(wb_valid), 32'h0);
    chk("rst_mem_fault", 32'(mem_fault), 32'h0);
    chk("rst_wb_data", {wb_data[0], wb_data[1], wb_data[2], wb_data[3]}, 32'h0);
    chk("rst_wb_words", wb_pc | wb_alu_result | wb_inst, 32'h0);
    chk("rst_wb_ctrl", {26'h0, wb_mem_block, wb_jump, wb_is_LB_SB, wb_mem_to_reg},
        32'h0);
    chk("rst_wb_reg_dst", 32'(wb_reg_dst), 32'h0);
    in_valid = 1'b0;
    rst_b = 1'b1;

    // Directed: ALU op, LW with 3-cycle cache, SB lane 3, misaligned SW.
    send(0, 0, 0, 0, 1, 2'b01, 32'h1000, 32'h1234, 32'h00851020, 32'h0, 0, 32'h0, 1);
    send(1, 0, 0, 1, 0, 2'b00, 32'h1004, 32'h100, 32'h8C000100, 32'h0, 2, 32'hDEADBEEF, 1);
    send(0, 1, 1, 0, 0, 2'b00, 32'h1008, 32'h203, 32'hA0000203, 32'h000000A5, 1, 32'h0, 1);
    send(0, 1, 0, 1, 0, 2'b00, 32'h100C, 32'h102, 32'hAC000102, 32'h12345678, 0, 32'h0, 1);
    send(1, 1, 1, 1, 1, 2'b10, 32'h1010, 32'h3FD, 32'h0, 32'hFFFFFFFF, 0, 32'hCAFEF00D, 1);

    // Directed: reset in the second ACCESS cycle, late cache_ready ignored.
    repeat (3) @(negedge clk);
    auto_cache = 1'b0;
    send(1, 0, 0, 1, 0, 2'b00, 32'h2000, 32'h300, 32'h8C000300, 32'h0, 0, 32'h0, 0);
    @(negedge clk);
    chk("rst_mid_req_on", 32'(cache_req), 32'h1);
    @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    chk("rst_mid_req_drop", 32'(cache_req), 32'h0);
    rst_b = 1'b1;
    cache_ready = 1'b1;
    @(negedge clk);
    cache_ready = 1'b0;
    chk("rst_mid_req_stays_low", 32'(cache_req), 32'h0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'h1);
    chk("rst_mid_no_wb", 32'(wb_valid), 32'h0);
    auto_cache = 1'b1;

    // Randomised mix.
    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 5);
      a = $urandom;
      rd = (k == 2 || k == 4);
      wr = (k == 3 || k == 5);
      lbsb = (k >= 4);
      if ((rd || wr) && $urandom_range(0, 7) == 0) begin rd = 1'b1; wr = 1'b1; end
      if (!lbsb && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      send(rd, wr, lbsb, 1'($urandom), 1'($urandom), 2'($urandom), $urandom, a,
           $urandom, $urandom, $urandom_range(0, 3), $urandom, 1);
    end

    guard = 0;
    while ((wb_q.size() != 0 || req_q.size() != 0) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_wb_queue", wb_q.size(), 32'h0);
    chk("drain_req_queue", req_q.size(), 32'h0);
    summary();
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline, between the EX/MEM register and the write-back stage. Converts LW/SW/LB/SB into a request/ready transaction on the data cache, stalls upstream while the access is in flight, and registers byte-lane read data plus the control fields write-back needs. Non-memory instructions pass through with one cycle of latency.

## Interface
Parameters:
- none (32-bit data path, 4 byte lanes, big-endian lane order are fixed)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_b  in  1  reset, synchronous, active-low
- in_valid  in  1  EX/MEM holds a valid instruction
- in_ready  out  1  stage accepts the instruction this cycle
- mem_read  in  1  load instruction
- mem_write  in  1  store instruction
- is_LB_SB  in  1  byte access (LB/SB); 0 = word (LW/SW)
- mem_to_reg, reg_dst  in  1 each  write-back controls, passed through
- jump  in  2  jump class, passed through
- pc, alu_result, inst  in  32 each  passed through; alu_result is the effective address
- store_data  in  32  rt value for stores
- cache_req  out  1  access request, held until cache_ready
- cache_we  out  1  1 = write
- cache_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- cache_data_in  out  4x8  write bytes, index 0 = MSB lane
- cache_byte_en  out  4  write lane enables, bit i = lane i
- cache_ready  in  1  one-cycle completion strobe
- cache_data_out  in  4x8  read word, valid with cache_ready
- wb_valid  out  1  write-back registers hold a new instruction
- wb_data  out  4x8  registered read bytes
- wb_mem_block  out  2  addr[1:0] of the access
- wb_is_LB_SB, wb_mem_to_reg, wb_reg_dst  out  1 each
- wb_jump  out  2; wb_pc, wb_alu_result, wb_inst  out  32 each
- mem_fault  out  1  registered; misaligned word access

## Operation
- States: IDLE, ACCESS. in_ready = (state == IDLE).
- IDLE, in_valid, no memory op: WB registers load inputs; wb_data cleared; wb_valid=1 next cycle.
- IDLE, in_valid, word access with addr[1:0]≠0: no cache request; pass through as non-memory, mem_fault=1, wb_mem_to_reg forced 0.
- IDLE, in_valid, legal memory op: capture address, controls, store lanes into holding registers; go ACCESS.
- ACCESS: cache_req=1; cache_we, cache_addr, cache_data_in, cache_byte_en driven from holding registers, stable until cache_ready.
- SW: lanes {sd[31:24],sd[23:16],sd[15:8],sd[7:0]}, byte_en 4'b1111.
- SB: lane addr[1:0] = sd[7:0], other lanes 0, byte_en one-hot at addr[1:0] (lane 0 → 4'b0001).
- Reads: byte_en 4'b0000.
- ACCESS & cache_ready: WB registers load held fields; wb_data = cache_data_out for reads, 0 for writes; wb_mem_block = addr[1:0]; wb_valid=1 next cycle; go IDLE.
- wb_valid is 1 for exactly one cycle per accepted instruction, else 0.
- in_valid while in ACCESS ignored; upstream holds it until in_ready.
- mem_read and mem_write both set: treated as read.
- cache_ready in IDLE: ignored.

## Timing
- Reset (rst_b=0 at edge): state IDLE, cache_req 0, all wb_* outputs and mem_fault 0, wb_data all zero. in_ready is 1 from the first post-reset cycle.
- Reset mid-ACCESS: request dropped next edge; any pending cache_ready ignored.
- Non-memory/fault latency: accept edge N, wb_valid high cycle N+1.
- Memory: accept edge N; cache_req high from cycle N+1; cache_ready sampled at edge M (M≥N+1); wb_valid high cycle M+1; in_ready high again cycle M+1 (back-to-back accept then possible).
- Minimum memory latency 2 cycles (cache_ready in first ACCESS cycle).
- mem_fault valid in the same cycle as its wb_valid.

## Test plan
- Reset: rst_b=0 for 2 cycles with in_valid=1 → in_ready=1, cache_req=0, all wb_* and mem_fault 0.
- ALU op (mem_read=mem_write=0, alu_result=0x1234) → wb_valid one cycle later, wb_alu_result=0x1234, no cache_req.
- LW addr 0x100, cache_ready after 3 cycles with bytes {DE,AD,BE,EF} → cache_addr=0x100, in_ready low 3 cycles, wb_data={DE,AD,BE,EF}, wb_mem_block=0.
- SB addr 0x203, store_data=0x000000A5 → byte_en=4'b1000, lane 3=A5, others 0, cache_we=1; wb_mem_block=3.
- SW addr 0x102 → no cache_req, mem_fault=1, wb_mem_to_reg=0, wb_valid after 1 cycle.
- LW accepted, rst_b=0 in second ACCESS cycle, cache_ready following cycle → cache_req 0, wb_valid never asserts.
